// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and instruction memory (slave).
interface fetch_queue_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generation, credit-limited in-order imem requests, response
// FIFO with post-redirect drop tracking, and the Decode instruction register.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stallF,
    input  logic                flushD,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    fetch_queue_unit_if.master  imem,
    output logic                validD,
    output logic [31:0]         instrD,
    output logic [XLEN-1:0]     pcD,
    output logic [XLEN-1:0]     pcplus4D
);
    localparam int          PW  = $clog2(QDEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] pcR;
    logic [CW-1:0]   outstandingR;
    logic [CW-1:0]   dropCntR;
    logic [CW-1:0]   fifoCountR;
    logic [PW-1:0]   fifoWrR;
    logic [PW-1:0]   fifoRdR;
    logic [PW-1:0]   pcqWrR;
    logic [PW-1:0]   pcqRdR;
    logic [XLEN-1:0] pcQ     [QDEPTH];
    logic [31:0]     instQ   [QDEPTH];
    logic [XLEN-1:0] instPcQ [QDEPTH];

    logic [CW:0]     inUseS;
    logic            creditS;
    logic            reqValidS;
    logic            fireS;
    logic            rspS;
    logic            acceptS;
    logic            fifoEmptyS;
    logic            dUpdateS;
    logic            popS;
    logic            bypassS;
    logic            pushS;
    logic [XLEN-1:0] rspPcS;

    assign inUseS     = {1'b0, outstandingR} + {1'b0, fifoCountR};
    assign creditS    = inUseS < (CW+1)'(QDEPTH);
    assign reqValidS  = !reset && !redirect_valid && creditS;
    assign fireS      = reqValidS && imem.imem_req_ready;
    assign rspS       = imem.imem_rsp_valid;
    // A response is live only if it is not owed to an earlier redirect.
    assign acceptS    = rspS && (dropCntR == CW'(0)) && !redirect_valid;
    assign fifoEmptyS = (fifoCountR == CW'(0));
    assign dUpdateS   = !redirect_valid && !flushD && !stallF;
    assign popS       = dUpdateS && !fifoEmptyS;
    assign bypassS    = dUpdateS && fifoEmptyS && acceptS;
    assign pushS      = acceptS && !bypassS;
    assign rspPcS     = pcQ[pcqRdR];

    assign imem.imem_req_valid = reqValidS;
    assign imem.imem_req_addr  = pcR;

    // Storage arrays: request-PC queue and instruction/PC FIFO (no reset needed).
    always_ff @(posedge clk) begin
        if (fireS) begin
            pcQ[pcqWrR] <= pcR;
        end
        if (pushS) begin
            instQ[fifoWrR]   <= imem.imem_rsp_data;
            instPcQ[fifoWrR] <= rspPcS;
        end
    end

    // PC, credit, drop and FIFO pointer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcR          <= RESET_PC;
            outstandingR <= CW'(0);
            dropCntR     <= CW'(0);
            fifoCountR   <= CW'(0);
            fifoWrR      <= PW'(0);
            fifoRdR      <= PW'(0);
            pcqWrR       <= PW'(0);
            pcqRdR       <= PW'(0);
        end else begin
            outstandingR <= outstandingR + CW'(fireS) - CW'(rspS);
            // The PC queue tracks every in-flight request, dropped or not.
            if (fireS) pcqWrR <= pcqWrR + PW'(1);
            if (rspS)  pcqRdR <= pcqRdR + PW'(1);
            if (redirect_valid) begin
                pcR        <= redirect_pc;
                dropCntR   <= outstandingR - CW'(rspS);
                fifoCountR <= CW'(0);
                fifoWrR    <= PW'(0);
                fifoRdR    <= PW'(0);
            end else begin
                if (fireS) pcR <= pcR + XLEN'(4);
                if (rspS && (dropCntR != CW'(0))) dropCntR <= dropCntR - CW'(1);
                if (pushS) fifoWrR <= fifoWrR + PW'(1);
                if (popS)  fifoRdR <= fifoRdR + PW'(1);
                fifoCountR <= fifoCountR + CW'(pushS) - CW'(popS);
            end
        end
    end

    // Decode register: flush/redirect beats stall; FIFO head beats bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            validD   <= 1'b0;
            instrD   <= NOP;
            pcD      <= XLEN'(0);
            pcplus4D <= XLEN'(0);
        end else if (redirect_valid || flushD) begin
            validD <= 1'b0;
            instrD <= NOP;
        end else if (stallF) begin
            validD <= validD;
        end else if (!fifoEmptyS) begin
            validD   <= 1'b1;
            instrD   <= instQ[fifoRdR];
            pcD      <= instPcQ[fifoRdR];
            pcplus4D <= instPcQ[fifoRdR] + XLEN'(4);
        end else if (acceptS) begin
            validD   <= 1'b1;
            instrD   <= imem.imem_rsp_data;
            pcD      <= rspPcS;
            pcplus4D <= rspPcS + XLEN'(4);
        end else begin
            validD <= 1'b0;
        end
    end

    fetch_queue_unit_chk #(.CW(CW), .QDEPTH(QDEPTH)) u_chk (
        .clk        (clk),
        .reset      (reset),
        .push       (pushS),
        .pop        (popS),
        .fifoCount  (fifoCountR)
    );
endmodule

// Invariant checks for the fetch FIFO.
module fetch_queue_unit_chk #(
    parameter int CW     = 3,
    parameter int QDEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] fifoCount
);
    // The credit rule must keep a push from ever landing on a full FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && (fifoCount == CW'(QDEPTH))))
                else $error("fetch FIFO overflow");
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: per-cycle vector table plus hand-written
// redirect, back-pressure and PC-wrap sequences against a latency-modelled imem.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stallF;
    logic        flushD;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;

    int passCnt  = 0;
    int totalCnt = 0;
    int cyc      = 0;
    int lat      = 1;

    logic [31:0] qAddr[$];
    int          qDue[$];

    fetch_queue_unit_if #(.XLEN(32)) bus();

    fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .stallF         (stallF),
        .flushD         (flushD),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .imem           (bus.master),
        .validD         (validD),
        .instrD         (instrD),
        .pcD            (pcD),
        .pcplus4D       (pcplus4D)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Memory model: accept requests late in the cycle, answer in order after lat cycles.
    always @(negedge clk) begin
        if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
            qAddr.push_back(bus.imem_req_addr);
            qDue.push_back(cyc + lat);
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            qAddr.delete();
            qDue.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end else if (qDue.size() > 0 && qDue[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instrOf(qAddr[0]);
            void'(qAddr.pop_front());
            void'(qDue.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else passCnt++;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset(input int l);
        reset         = 1'b1;
        stallF        = 1'b0;
        flushD        = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        bus.imem_req_ready = 1'b1;
        lat           = l;
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic chkD(input string nm, input logic [31:0] expPc);
        chk({nm, "_valid"}, {31'h0, validD}, 32'h1);
        chk({nm, "_pcD"}, pcD, expPc);
        chk({nm, "_instrD"}, instrD, instrOf(expPc));
        chk({nm, "_pcplus4D"}, pcplus4D, expPc + 32'h4);
    endtask

    task automatic waitValid(input string nm, input int expWait, input logic [31:0] expPc);
        int n;
        n = 0;
        while (!validD && n < 20) begin
            nextCycle();
            @(negedge clk);
            n++;
        end
        chk({nm, "_wait"}, n, expWait);
        chkD(nm, expPc);
    endtask

    typedef struct {
        bit          stall;
        bit          flush;
        bit          expValid;
        logic [31:0] expPc;
        bit          expReq;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[21];

    initial begin
        // Steady stream, 5-cycle stall fill, then flushD together with stallF.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h08};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h0C};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h10};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h14};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h18};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h1C};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h24};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h24};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h24};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h24};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h28};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h2C};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h30};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h34};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h38};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h28, 1'b1, 32'h38};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 32'h2C, 1'b1, 32'h3C};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 32'h40};

        reset         = 1'b1;
        stallF        = 1'b0;
        flushD        = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        bus.imem_req_ready = 1'b1;
        nextCycle();
        @(negedge clk);
        chk("rst_validD", {31'h0, validD}, 32'h0);
        chk("rst_instrD", instrD, 32'h0000_0013);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_pcplus4D", pcplus4D, 32'h0);
        chk("rst_reqValid", {31'h0, bus.imem_req_valid}, 32'h0);

        doReset(1);
        for (int k = 0; k < 21; k++) begin
            stallF = vecs[k].stall;
            flushD = vecs[k].flush;
            @(negedge clk);
            chk($sformatf("vec%0d_validD", k), {31'h0, validD}, {31'h0, vecs[k].expValid});
            chk($sformatf("vec%0d_reqValid", k), {31'h0, bus.imem_req_valid}, {31'h0, vecs[k].expReq});
            chk($sformatf("vec%0d_reqAddr", k), bus.imem_req_addr, vecs[k].expAddr);
            if (vecs[k].expValid) chkD($sformatf("vec%0d", k), vecs[k].expPc);
            nextCycle();
        end

        // Redirect with three requests in flight at 4-cycle latency.
        doReset(4);
        repeat (3) nextCycle();
        redirectValid = 1'b1;
        redirectPc    = 32'h100;
        @(negedge clk);
        chk("redir1_noReq", {31'h0, bus.imem_req_valid}, 32'h0);
        nextCycle();
        redirectValid = 1'b0;
        @(negedge clk);
        chk("redir1_reqValid", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("redir1_reqAddr", bus.imem_req_addr, 32'h100);
        chk("redir1_validDlow", {31'h0, validD}, 32'h0);
        waitValid("redir1_first", 5, 32'h100);

        // Redirect on a response cycle, then a second redirect one cycle later.
        doReset(2);
        repeat (3) nextCycle();
        @(negedge clk);
        chkD("redir2_pre", 32'h0);
        redirectValid = 1'b1;
        redirectPc    = 32'h100;
        nextCycle();
        redirectPc = 32'h200;
        @(negedge clk);
        chk("redir2_validDlow", {31'h0, validD}, 32'h0);
        chk("redir2_noReq", {31'h0, bus.imem_req_valid}, 32'h0);
        nextCycle();
        redirectValid = 1'b0;
        @(negedge clk);
        chk("redir2_reqAddr", bus.imem_req_addr, 32'h200);
        waitValid("redir2_first", 3, 32'h200);
        nextCycle();
        @(negedge clk);
        chkD("redir2_second", 32'h204);

        // Request held with ready low, then PC wrap at the top of the address space.
        doReset(1);
        bus.imem_req_ready = 1'b0;
        redirectValid      = 1'b1;
        redirectPc         = 32'h40;
        nextCycle();
        redirectValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_reqValid", k), {31'h0, bus.imem_req_valid}, 32'h1);
            chk($sformatf("hold%0d_reqAddr", k), bus.imem_req_addr, 32'h40);
            nextCycle();
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        chk("hold_fireAddr", bus.imem_req_addr, 32'h40);
        nextCycle();
        @(negedge clk);
        chk("hold_nextAddr", bus.imem_req_addr, 32'h44);
        chk("hold_validDlow", {31'h0, validD}, 32'h0);
        nextCycle();
        redirectValid = 1'b1;
        redirectPc    = 32'hFFFF_FFFC;
        @(negedge clk);
        chkD("hold_first", 32'h40);
        nextCycle();
        redirectValid = 1'b0;
        @(negedge clk);
        chk("wrap_addrTop", bus.imem_req_addr, 32'hFFFF_FFFC);
        nextCycle();
        @(negedge clk);
        chk("wrap_addrZero", bus.imem_req_addr, 32'h0);
        nextCycle();
        @(negedge clk);
        chkD("wrap_D", 32'hFFFF_FFFC);
        chk("wrap_pcplus4Zero", pcplus4D, 32'h0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
